// File: rtl/udt_link_channel.sv
// udt_link_channel: store-and-forward AXI-stream link emulator for the 64-bit
// MAC loopback path. Whole frames are buffered and only committed frames are
// released. Frames are dropped deterministically (every DROP_EVERY-th frame
// when drop_en is set) or when they do not fit in the buffer.
module udt_link_channel #(
  parameter int DEPTH      = 512,
  parameter int DROP_EVERY = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk156,
  input  logic             core_rst_n,
  input  logic             drop_en,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] frames_in,
  output logic [CNT_W-1:0] frames_out,
  output logic [CNT_W-1:0] drops_policy,
  output logic [CNT_W-1:0] drops_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = (DROP_EVERY > 1) ? $clog2(DROP_EVERY) : 1;
  localparam bit POLICY_ON = (DROP_EVERY != 0);
  localparam logic [IW-1:0]    IDX_LAST  = (DROP_EVERY > 0) ? IW'(DROP_EVERY - 1) : '0;
  localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]    FULL_FILL = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_DISCARD_POL,
    S_DISCARD_OVF
  } wr_state_e;

  wr_state_e        state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic [IW-1:0]    frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0] frames_in_q, frames_in_d;
  logic [CNT_W-1:0] frames_out_q, frames_out_d;
  logic [CNT_W-1:0] drops_policy_q, drops_policy_d;
  logic [CNT_W-1:0] drops_ovf_q, drops_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             tready_q;
  logic [72:0]      rd_beat_q;

  // Frame buffer: {tlast, tkeep, tdata} per beat
  logic [72:0] mem [DEPTH];

  logic beat, rd_en, wr_en, commit, egress_last, full_after, policy_drop;

  // Next-state logic for the write FSM, pointers, read issue and statistics
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    commit_ptr_d   = commit_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    pending_d      = pending_q;
    frame_idx_d    = frame_idx_q;
    frames_in_d    = frames_in_q;
    frames_out_d   = frames_out_q;
    drops_policy_d = drops_policy_q;
    drops_ovf_d    = drops_ovf_q;
    wr_en          = 1'b0;
    commit         = 1'b0;

    beat = s_axis_tvalid && tready_q;

    // Fetch the next committed beat whenever the output register is free or draining.
    rd_en = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || m_axis_tready);
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    egress_last = out_valid_q && m_axis_tready && rd_beat_q[72];

    // Fullness is judged after this cycle's read so a freed slot is reusable at once.
    full_after  = ((wr_ptr_q - rd_ptr_d) == FULL_FILL);
    policy_drop = POLICY_ON && drop_en && (frame_idx_q == IDX_LAST);

    case (state_q)
      S_IDLE, S_ACCEPT: begin
        if (beat) begin
          if ((state_q == S_IDLE) && policy_drop) begin
            if (s_axis_tlast) begin
              drops_policy_d = drops_policy_q + CNT_ONE;
            end else begin
              state_d = S_DISCARD_POL;
            end
          end else if (full_after) begin
            // Abandon the partial frame by rewinding to the last commit point.
            wr_ptr_d = commit_ptr_q;
            if (s_axis_tlast) begin
              drops_ovf_d = drops_ovf_q + CNT_ONE;
              state_d     = S_IDLE;
            end else begin
              state_d = S_DISCARD_OVF;
            end
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              state_d      = S_IDLE;
            end else begin
              state_d = S_ACCEPT;
            end
          end
        end
      end
      S_DISCARD_POL: begin
        if (beat && s_axis_tlast) begin
          drops_policy_d = drops_policy_q + CNT_ONE;
          state_d        = S_IDLE;
        end
      end
      S_DISCARD_OVF: begin
        if (beat && s_axis_tlast) begin
          drops_ovf_d = drops_ovf_q + CNT_ONE;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit && !egress_last) begin
      pending_d = pending_q + PTR_ONE;
    end else if (!commit && egress_last) begin
      pending_d = pending_q - PTR_ONE;
    end

    if (egress_last) begin
      frames_out_d = frames_out_q + CNT_ONE;
    end

    if (beat && s_axis_tlast) begin
      frames_in_d = frames_in_q + CNT_ONE;
      frame_idx_d = (POLICY_ON && (frame_idx_q == IDX_LAST)) ? '0 : frame_idx_q + IDX_ONE;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk156) begin
    if (!core_rst_n) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      rd_ptr_q       <= '0;
      pending_q      <= '0;
      frame_idx_q    <= '0;
      frames_in_q    <= '0;
      frames_out_q   <= '0;
      drops_policy_q <= '0;
      drops_ovf_q    <= '0;
      out_valid_q    <= 1'b0;
      tready_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      commit_ptr_q   <= commit_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pending_q      <= pending_d;
      frame_idx_q    <= frame_idx_d;
      frames_in_q    <= frames_in_d;
      frames_out_q   <= frames_out_d;
      drops_policy_q <= drops_policy_d;
      drops_ovf_q    <= drops_ovf_d;
      out_valid_q    <= out_valid_d;
      tready_q       <= 1'b1;
    end
  end

  // RAM write port
  always_ff @(posedge clk156) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Registered RAM read; holds its value while egress is stalled
  always_ff @(posedge clk156) begin
    if (!core_rst_n) begin
      rd_beat_q <= '0;
    end else if (rd_en) begin
      rd_beat_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = rd_beat_q[72];
  assign m_axis_tkeep  = rd_beat_q[71:64];
  assign m_axis_tdata  = rd_beat_q[63:0];
  assign frames_in     = frames_in_q;
  assign frames_out    = frames_out_q;
  assign drops_policy  = drops_policy_q;
  assign drops_ovf     = drops_ovf_q;

endmodule
